ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 175 +++++++++++++++++
 tb/tb_ex_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// Execute stage of a 5-stage pipeline that can also ship ALU results onto a
// NoC through a one-entry flit buffer.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   Jump_E/Beq_E/Bneq_E      control-flow type of the EX instruction
//   RegW_enable_E            register write request
//   ALU_src_E                1: srcB = extend_out_E, 0: srcB = rd2_E
//   ALU_control_E[3:0]       ALU operation
//   Mem_Write_E              store request
//   Result_src_E             writeback mux select, passed through
//   rd1_E, rd2_E             register operands (rd2_E is also store data)
//   Radd_E[4:0]              destination register
//   extend_out_E             sign/zero-extended immediate
//   PC_E                     address of the EX instruction
//   dest_add_E[1:0]          NoC destination node
//   proc_valid_E             EX instruction is valid
//   alu_out_E                EX instruction sends its ALU result to the NoC
//   noc_ready_in             router accepts the flit this cycle
//   *_M outputs              EX/MEM pipeline register
//   PC_src_E, PC_target_E    combinational PC redirect
//   stall_E                  combinational; upstream must hold the EX instr
//   noc_valid, noc_flit      flit buffer full / flit {dest, data}
//
// Handshake: a flit transfers on any cycle where noc_valid=1 and
// noc_ready_in=1. While noc_valid=1 and noc_ready_in=0, noc_flit is held
// stable. noc_valid is exactly "send FSM is in FULL", so it also serves as
// the observable FSM state.
// -----------------------------------------------------------------------------
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        Jump_E,
  input  logic        Beq_E,
  input  logic        Bneq_E,
  input  logic        RegW_enable_E,
  input  logic        ALU_src_E,
  input  logic [3:0]  ALU_control_E,
  input  logic        Mem_Write_E,
  input  logic        Result_src_E,
  input  logic [31:0] rd1_E,
  input  logic [31:0] rd2_E,
  input  logic [4:0]  Radd_E,
  input  logic [31:0] extend_out_E,
  input  logic [31:0] PC_E,
  input  logic [1:0]  dest_add_E,
  input  logic        proc_valid_E,
  input  logic        alu_out_E,
  input  logic        noc_ready_in,
  output logic [31:0] ALU_result_M,
  output logic [31:0] WriteData_M,
  output logic [4:0]  Radd_M,
  output logic        RegW_enable_M,
  output logic        Mem_Write_M,
  output logic        Result_src_M,
  output logic        PC_src_E,
  output logic [31:0] PC_target_E,
  output logic        stall_E,
  output logic        noc_valid,
  output logic [33:0] noc_flit
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FULL = 1'b1
  } send_state_t;

  send_state_t r_state, w_state_next;

  logic [31:0] w_srcb;
  logic [31:0] w_alu_result;
  logic [4:0]  w_shamt;
  logic        w_zero;
  logic        w_send_req;
  logic        w_load;
  logic        w_bubble;
  logic [33:0] r_flit;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  assign w_srcb  = ALU_src_E ? extend_out_E : rd2_E;
  assign w_shamt = w_srcb[4:0];

  always_comb begin
    w_alu_result = 32'd0;
    case (ALU_control_E)
      4'b0000: w_alu_result = rd1_E + w_srcb;
      4'b0001: w_alu_result = rd1_E - w_srcb;
      4'b0010: w_alu_result = rd1_E & w_srcb;
      4'b0011: w_alu_result = rd1_E | w_srcb;
      4'b0100: w_alu_result = rd1_E ^ w_srcb;
      4'b0101: w_alu_result = ~(rd1_E | w_srcb);
      4'b0110: w_alu_result = {31'd0, $signed(rd1_E) < $signed(w_srcb)};
      4'b0111: w_alu_result = {31'd0, rd1_E < w_srcb};
      4'b1000: w_alu_result = rd1_E << w_shamt;
      4'b1001: w_alu_result = rd1_E >> w_shamt;
      4'b1010: w_alu_result = 32'($signed(rd1_E) >>> w_shamt);
      4'b1011: w_alu_result = {w_srcb[15:0], 16'd0};
      default: w_alu_result = 32'd0;
    endcase
  end

  assign w_zero = (w_alu_result == 32'd0);

  // ---------------------------------------------------------------------------
  // Branch / jump redirect
  // ---------------------------------------------------------------------------
  // A stalled instruction is replayed next cycle, so it must not redirect yet.
  assign PC_src_E = proc_valid_E & ~stall_E &
                    (Jump_E | (Beq_E & w_zero) | (Bneq_E & ~w_zero));

  assign PC_target_E = Jump_E ? {PC_E[31:28], extend_out_E[25:0], 2'b00}
                              : PC_E + 32'd4 + (extend_out_E << 2);

  // ---------------------------------------------------------------------------
  // NoC send FSM
  // ---------------------------------------------------------------------------
  assign w_send_req = proc_valid_E & alu_out_E;

  // Only blocked case: buffer occupied, router not taking it, new send waiting.
  assign stall_E = (r_state == S_FULL) & ~noc_ready_in & w_send_req;

  // In IDLE, or FULL with the old flit leaving this cycle, a send loads.
  assign w_load = w_send_req & ~stall_E;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_send_req) w_state_next = S_FULL;
      S_FULL: if (noc_ready_in && !w_send_req) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_flit  <= 34'd0;
    end else begin
      r_state <= w_state_next;
      if (w_load) r_flit <= {dest_add_E, w_alu_result};
    end
  end

  assign noc_valid = (r_state == S_FULL);
  assign noc_flit  = r_flit;

  // ---------------------------------------------------------------------------
  // EX/MEM register
  // ---------------------------------------------------------------------------
  assign w_bubble = ~proc_valid_E | stall_E;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_result_M  <= 32'd0;
      WriteData_M   <= 32'd0;
      Radd_M        <= 5'd0;
      RegW_enable_M <= 1'b0;
      Mem_Write_M   <= 1'b0;
      Result_src_M  <= 1'b0;
    end else begin
      // Data fields are don't-care in a bubble, so they load unconditionally.
      ALU_result_M  <= w_alu_result;
      WriteData_M   <= rd2_E;
      Radd_M        <= Radd_E;
      Result_src_M  <= Result_src_E;
      RegW_enable_M <= RegW_enable_E & ~w_bubble;
      Mem_Write_M   <= Mem_Write_E & ~w_bubble;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        Jump_E, Beq_E, Bneq_E, RegW_enable_E, ALU_src_E;
  logic [3:0]  ALU_control_E;
  logic        Mem_Write_E, Result_src_E;
  logic [31:0] rd1_E, rd2_E, extend_out_E, PC_E;
  logic [4:0]  Radd_E;
  logic [1:0]  dest_add_E;
  logic        proc_valid_E, alu_out_E, noc_ready_in;
  logic [31:0] ALU_result_M, WriteData_M, PC_target_E;
  logic [4:0]  Radd_M;
  logic        RegW_enable_M, Mem_Write_M, Result_src_M, PC_src_E, stall_E, noc_valid;
  logic [33:0] noc_flit;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .Jump_E(Jump_E), .Beq_E(Beq_E), .Bneq_E(Bneq_E),
    .RegW_enable_E(RegW_enable_E), .ALU_src_E(ALU_src_E),
    .ALU_control_E(ALU_control_E), .Mem_Write_E(Mem_Write_E),
    .Result_src_E(Result_src_E), .rd1_E(rd1_E), .rd2_E(rd2_E),
    .Radd_E(Radd_E), .extend_out_E(extend_out_E), .PC_E(PC_E),
    .dest_add_E(dest_add_E), .proc_valid_E(proc_valid_E),
    .alu_out_E(alu_out_E), .noc_ready_in(noc_ready_in),
    .ALU_result_M(ALU_result_M), .WriteData_M(WriteData_M),
    .Radd_M(Radd_M), .RegW_enable_M(RegW_enable_M),
    .Mem_Write_M(Mem_Write_M), .Result_src_M(Result_src_M),
    .PC_src_E(PC_src_E), .PC_target_E(PC_target_E), .stall_E(stall_E),
    .noc_valid(noc_valid), .noc_flit(noc_flit)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Jump_E = 0; Beq_E = 0; Bneq_E = 0; RegW_enable_E = 0; ALU_src_E = 0;
    ALU_control_E = 4'b0000; Mem_Write_E = 0; Result_src_E = 0;
    rd1_E = 0; rd2_E = 0; Radd_E = 0; extend_out_E = 0; PC_E = 0;
    dest_add_E = 0; proc_valid_E = 0; alu_out_E = 0; noc_ready_in = 0;
  endtask

  // Valid ADD-immediate style send of value v to node d.
  task automatic drive_send(input logic [31:0] v, input logic [1:0] d);
    idle_inputs();
    proc_valid_E = 1; alu_out_E = 1; RegW_enable_E = 1;
    rd1_E = v; ALU_control_E = 4'b0000; dest_add_E = d; Radd_E = 5'd9;
  endtask

  task automatic check_m_zero(input string tag);
    check({tag, " ALU_result_M"}, 64'(ALU_result_M), 64'd0);
    check({tag, " WriteData_M"}, 64'(WriteData_M), 64'd0);
    check({tag, " Radd_M"}, 64'(Radd_M), 64'd0);
    check({tag, " RegW_enable_M"}, 64'(RegW_enable_M), 64'd0);
    check({tag, " Mem_Write_M"}, 64'(Mem_Write_M), 64'd0);
    check({tag, " Result_src_M"}, 64'(Result_src_M), 64'd0);
    check({tag, " noc_valid"}, 64'(noc_valid), 64'd0);
    check({tag, " noc_flit"}, 64'(noc_flit), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] rd1, rd2, ext;
    logic        src;
    logic [3:0]  op;
    logic        beq, bneq, jmp, valid;
    logic [31:0] pc;
    logic [31:0] res;
    logic        pcsrc;
    logic [31:0] tgt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [31:0] rd1, rd2, ext, input logic src,
                              input logic [3:0] op, input logic beq, bneq, jmp, valid,
                              input logic [31:0] pc, res, input logic pcsrc,
                              input logic [31:0] tgt);
    vec_t v;
    v.rd1 = rd1; v.rd2 = rd2; v.ext = ext; v.src = src; v.op = op;
    v.beq = beq; v.bneq = bneq; v.jmp = jmp; v.valid = valid; v.pc = pc;
    v.res = res; v.pcsrc = pcsrc; v.tgt = tgt;
    return v;
  endfunction

  initial begin
    //            rd1           rd2           ext           src op      beq bneq jmp val pc            result        pcs tgt
    vecs[0]  = mk(32'd5,        32'd7,        32'd0,        0, 4'b0000, 0, 0, 0, 1, 32'h0,        32'd12,       0, 32'h4);
    vecs[1]  = mk(32'h80000000, 32'd0,        32'd4,        1, 4'b1010, 0, 0, 0, 1, 32'h0,        32'hF8000000, 0, 32'h14);
    vecs[2]  = mk(32'hFFFFFFFF, 32'd1,        32'd0,        0, 4'b0110, 0, 0, 0, 1, 32'h0,        32'd1,        0, 32'h4);
    vecs[3]  = mk(32'hFFFFFFFF, 32'd1,        32'd0,        0, 4'b0111, 0, 0, 0, 1, 32'h0,        32'd0,        0, 32'h4);
    vecs[4]  = mk(32'd3,        32'd3,        32'd2,        0, 4'b0001, 1, 0, 0, 1, 32'h100,      32'd0,        1, 32'h10C);
    vecs[5]  = mk(32'd3,        32'd3,        32'd2,        0, 4'b0001, 1, 0, 0, 0, 32'h100,      32'd0,        0, 32'h10C);
    vecs[6]  = mk(32'd5,        32'd3,        32'hFFFFFFFF, 0, 4'b0001, 0, 1, 0, 1, 32'h200,      32'd2,        1, 32'h200);
    vecs[7]  = mk(32'hF0F0F0F0, 32'hFF00FF00, 32'h40,       0, 4'b0010, 0, 0, 1, 1, 32'hA0000010, 32'hF000F000, 1, 32'hA0000100);
    vecs[8]  = mk(32'hF0F0F0F0, 32'hFF00FF00, 32'h40,       0, 4'b0011, 0, 0, 0, 1, 32'h0,        32'hFFF0FFF0, 0, 32'h104);
    vecs[9]  = mk(32'hF0F0F0F0, 32'hFF00FF00, 32'h40,       0, 4'b0100, 0, 0, 0, 1, 32'h0,        32'h0FF00FF0, 0, 32'h104);
    vecs[10] = mk(32'hF0F0F0F0, 32'hFF00FF00, 32'h40,       0, 4'b0101, 0, 0, 0, 1, 32'h0,        32'h000F000F, 0, 32'h104);
    vecs[11] = mk(32'd1,        32'd0,        32'h1F,       1, 4'b1000, 0, 0, 0, 1, 32'h0,        32'h80000000, 0, 32'h80);
    vecs[12] = mk(32'h80000000, 32'd0,        32'h1F,       1, 4'b1001, 0, 0, 0, 1, 32'h0,        32'd1,        0, 32'h80);
    vecs[13] = mk(32'd0,        32'd0,        32'h1234,     1, 4'b1011, 0, 0, 0, 1, 32'h0,        32'h12340000, 0, 32'h48D4);
    vecs[14] = mk(32'd9,        32'd9,        32'd0,        0, 4'b1111, 1, 0, 0, 1, 32'h0,        32'd0,        1, 32'h4);
    vecs[15] = mk(32'h80000000, 32'd0,        32'h24,       1, 4'b1010, 0, 0, 0, 1, 32'h0,        32'hF8000000, 0, 32'h94);
    vecs[16] = mk(32'hFFFFFFFF, 32'd1,        32'd0,        0, 4'b0000, 0, 1, 0, 1, 32'h0,        32'd0,        0, 32'h4);
    vecs[17] = mk(32'd5,        32'd3,        32'd0,        0, 4'b0001, 1, 0, 0, 1, 32'h0,        32'd2,        0, 32'h4);
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    #12;
    check_m_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table-driven ALU / redirect / EX-MEM checks
    for (int i = 0; i < NV; i++) begin
      idle_inputs();
      rd1_E = vecs[i].rd1; rd2_E = vecs[i].rd2; extend_out_E = vecs[i].ext;
      ALU_src_E = vecs[i].src; ALU_control_E = vecs[i].op;
      Beq_E = vecs[i].beq; Bneq_E = vecs[i].bneq; Jump_E = vecs[i].jmp;
      proc_valid_E = vecs[i].valid; PC_E = vecs[i].pc;
      RegW_enable_E = 1; Mem_Write_E = i[0]; Result_src_E = i[1]; Radd_E = 5'(i);
      #1;
      check($sformatf("v%0d PC_src_E", i), 64'(PC_src_E), 64'(vecs[i].pcsrc));
      check($sformatf("v%0d PC_target_E", i), 64'(PC_target_E), 64'(vecs[i].tgt));
      check($sformatf("v%0d stall_E", i), 64'(stall_E), 64'd0);
      tick();
      check($sformatf("v%0d ALU_result_M", i), 64'(ALU_result_M), 64'(vecs[i].res));
      check($sformatf("v%0d RegW_enable_M", i), 64'(RegW_enable_M), 64'(vecs[i].valid));
      check($sformatf("v%0d Mem_Write_M", i), 64'(Mem_Write_M), 64'(vecs[i].valid & i[0]));
      check($sformatf("v%0d WriteData_M", i), 64'(WriteData_M), 64'(vecs[i].rd2));
      check($sformatf("v%0d Radd_M", i), 64'(Radd_M), 64'(i));
      check($sformatf("v%0d Result_src_M", i), 64'(Result_src_M), 64'(i[1]));
      check($sformatf("v%0d noc_valid", i), 64'(noc_valid), 64'd0);
    end

    // NoC backpressure: flit held for 3 not-ready cycles plus the accept cycle
    drive_send(32'h55, 2'd2);
    #1;
    check("bp stall on load", 64'(stall_E), 64'd0);
    tick();
    check("bp RegW_enable_M", 64'(RegW_enable_M), 64'd1);
    check("bp ALU_result_M", 64'(ALU_result_M), 64'h55);
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      noc_ready_in = (c == 3);
      #1;
      check($sformatf("bp c%0d noc_valid", c), 64'(noc_valid), 64'd1);
      check($sformatf("bp c%0d noc_flit", c), 64'(noc_flit), 64'h2_00000055);
      tick();
    end
    check("bp drained noc_valid", 64'(noc_valid), 64'd0);

    // Back-to-back sends with the second one stalled
    drive_send(32'h11, 2'd1);
    tick();
    drive_send(32'h22, 2'd3);
    Jump_E = 1; Mem_Write_E = 1; noc_ready_in = 0;
    #1;
    check("b2b stall_E", 64'(stall_E), 64'd1);
    check("b2b PC_src_E forced", 64'(PC_src_E), 64'd0);
    tick();
    check("b2b bubble RegW", 64'(RegW_enable_M), 64'd0);
    check("b2b bubble MemW", 64'(Mem_Write_M), 64'd0);
    check("b2b flit held", 64'(noc_flit), 64'h1_00000011);
    noc_ready_in = 1;
    #1;
    check("b2b release stall_E", 64'(stall_E), 64'd0);
    check("b2b release PC_src_E", 64'(PC_src_E), 64'd1);
    tick();
    check("b2b second flit", 64'(noc_flit), 64'h3_00000022);
    check("b2b noc_valid", 64'(noc_valid), 64'd1);
    check("b2b RegW_enable_M", 64'(RegW_enable_M), 64'd1);
    check("b2b Mem_Write_M", 64'(Mem_Write_M), 64'd1);
    idle_inputs();
    noc_ready_in = 1;
    tick();
    check("b2b drained", 64'(noc_valid), 64'd0);

    // Reset asserted while a flit is pending
    drive_send(32'hABCD, 2'd1);
    tick();
    idle_inputs();
    check("rst-mid pre noc_valid", 64'(noc_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_m_zero("rst-mid");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post-rst noc_valid", 64'(noc_valid), 64'd0);
    check("post-rst noc_flit", 64'(noc_flit), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
